// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 key-schedule constants, S-box lookup and round-key type
package aes_pkg;
  localparam int NR_128 = 10;
  typedef logic [127:0] rk_t;
  typedef enum logic {IDLE = 1'b0, EXPAND = 1'b1} state_t;
  // Rcon by round index; entry 0 and entries above 10 are never used by a 10-round schedule
  localparam logic [7:0] RCON [16] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                       8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  // S-box packed with entry 0x00 in the top byte
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/aes_key_step.sv
// aes_key_step: one combinational AES-128 key-expansion round (prev_rk, rcon -> next_rk)
module aes_key_step
  import aes_pkg::*;
(
  input  rk_t        prev_rk,
  input  logic [7:0] rcon,
  output rk_t        next_rk
);
  logic [31:0] w0, w1, w2, w3, t;
  assign {w0, w1, w2, w3} = prev_rk;
  // SubWord(RotWord(w3)): rotation folded into the byte order of the lookups
  assign t = {sbox(w3[23:16]) ^ rcon, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
  assign next_rk[127:96] = w0 ^ t;
  assign next_rk[95:64]  = w1 ^ next_rk[127:96];
  assign next_rk[63:32]  = w2 ^ next_rk[95:64];
  assign next_rk[31:0]   = w3 ^ next_rk[63:32];
endmodule

// File: rtl/aes_key_sched_seq.sv
// aes_key_sched_seq: sequential AES-128 key expansion into an (NR+1)-entry round-key buffer
// Ports: clk, rst (async high), start/key_in request an expansion; busy, done (pulse),
// keys_valid report progress; rk_addr/rk_data is a registered 1-cycle read port (0 above NR).
module aes_key_sched_seq
  import aes_pkg::*;
#(
  parameter int NR = NR_128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  input  logic [3:0]   rk_addr,
  output logic [127:0] rk_data
);
  localparam logic [3:0] NR4 = 4'(NR);
  state_t     state_q;
  rk_t        rk_q [NR+1];
  rk_t        rd_q, rk_d;
  logic [3:0] cnt_q;
  logic       done_q, kv_q;
  aes_key_step u_step (
    .prev_rk(rk_q[cnt_q - 4'd1]),
    .rcon   (RCON[cnt_q]),
    .next_rk(rk_d)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      kv_q    <= 1'b0;
      rd_q    <= '0;
      for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      rd_q   <= rk_addr <= NR4 ? rk_q[rk_addr] : '0;
      if (state_q == EXPAND) begin
        rk_q[cnt_q] <= rk_d;
        // counter parks at NR on the final write so it never leaves 0..NR
        cnt_q <= cnt_q + {3'b000, cnt_q != NR4};
        if (cnt_q == NR4) begin
          state_q <= IDLE;
          kv_q    <= 1'b1;
          done_q  <= 1'b1;
        end
      end else if (start) begin
        rk_q[0] <= key_in;
        state_q <= EXPAND;
        cnt_q   <= 4'd1;
        kv_q    <= 1'b0;
      end
    end
  assign busy       = state_q == EXPAND;
  assign done       = done_q;
  assign keys_valid = kv_q;
  assign rk_data    = rd_q;
endmodule

// File: tb/tb_aes_key_sched_seq.sv
// tb_aes_key_sched_seq: scoreboard bench for the AES-128 key schedule sequencer
module tb_aes_key_sched_seq;
  logic         clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [127:0] key_in = '0;
  logic         busy, done, keys_valid;
  logic [3:0]   rk_addr = '0;
  logic [127:0] rk_data;
  localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K1_RK2 = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] K1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_RK2  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
  localparam logic [127:0] Z_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  logic [127:0] exp_q [$];
  int n_chk = 0, n_pass = 0, n;
  aes_key_sched_seq dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .busy(busy), .done(done),
    .keys_valid(keys_valid), .rk_addr(rk_addr), .rk_data(rk_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  task automatic rd(input string tag, input logic [3:0] a, input logic [127:0] e);
    rk_addr = a;
    exp_q.push_back(e);
    @(negedge clk);
    chk(tag, rk_data, exp_q.pop_front());
  endtask
  task automatic go(input logic [127:0] k);
    start  = 1'b1;
    key_in = k;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 128'(busy), 0);
    chk("rst_done", 128'(done), 0);
    chk("rst_kv", 128'(keys_valid), 0);
    chk("rst_data", rk_data, 0);
    rst = 1'b0;
    rd("idle_rd", 4'd3, 0);
    go(K1);
    chk("a_busy", 128'(busy), 1);
    chk("a_kv", 128'(keys_valid), 0);
    wait_done(n);
    chk("a_lat", 128'(n), 10);
    chk("a_kv_done", 128'(keys_valid), 1);
    chk("a_busy_done", 128'(busy), 0);
    rd("a_done_pulse_rk0", 4'd0, K1);
    chk("a_done_low", 128'(done), 0);
    rd("a_rk1", 4'd1, K1_RK1);
    rd("a_rk2", 4'd2, K1_RK2);
    rd("a_rk10", 4'd10, K1_RK10);
    for (int a = 11; a <= 15; a++) rd("a_oor", 4'(a), 0);
    go(K1);
    wait_done(n);
    chk("b_lat1", 128'(n), 10);
    go('0);
    chk("b_kv_drop", 128'(keys_valid), 0);
    chk("b_busy", 128'(busy), 1);
    wait_done(n);
    chk("b_lat2", 128'(n), 10);
    rd("b_rk0", 4'd0, 0);
    rd("b_rk1", 4'd1, Z_RK1);
    rd("b_rk2", 4'd2, Z_RK2);
    rd("b_rk10", 4'd10, Z_RK10);
    go(K1);
    repeat (3) @(negedge clk);
    go('0);
    chk("c_busy", 128'(busy), 1);
    wait_done(n);
    chk("c_lat", 128'(n), 6);
    rd("c_rk0", 4'd0, K1);
    rd("c_rk1", 4'd1, K1_RK1);
    rd("c_rk10", 4'd10, K1_RK10);
    go(K1);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("d_busy", 128'(busy), 0);
    chk("d_done", 128'(done), 0);
    chk("d_kv", 128'(keys_valid), 0);
    chk("d_data", rk_data, 0);
    @(negedge clk);
    rst = 1'b0;
    rd("d_clr_rk1", 4'd1, 0);
    go('0);
    wait_done(n);
    chk("d_lat", 128'(n), 10);
    chk("d_kv_done", 128'(keys_valid), 1);
    rd("d_rk10", 4'd10, Z_RK10);
    rd("d_rk1", 4'd1, Z_RK1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/aes_key_sched_seq.md
AES_KEY_SCHED_SEQ -- requirements
Module: aes_key_sched_seq

Interface
REQ-001 The block SHALL have parameter NR, default 10, meaning the number of AES-128 rounds; it sets the round-key buffer depth to NR+1.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: key-expansion request; it is sampled on each clk edge.
REQ-005 The block SHALL have port key_in, input, 128 bits: the cipher key, with byte 0 in bits [127:120].
REQ-006 The block SHALL have port busy, output, 1 bit: high while expansion is in progress.
REQ-007 The block SHALL have port done, output, 1 bit: a one-cycle pulse when round key NR has been written.
REQ-008 The block SHALL have port keys_valid, output, 1 bit: high when the buffer holds a complete schedule for the last accepted key.
REQ-009 The block SHALL have port rk_addr, input, 4 bits: the round-key read index.
REQ-010 The block SHALL have port rk_data, output, 128 bits: the registered round key for rk_addr.

Function
REQ-011 A start SHALL be accepted on an edge where start=1 and busy=0: RK[0]<=key_in, busy<=1, cnt<=1, keys_valid<=0.
REQ-012 A start sampled while busy=1 SHALL be ignored, with no effect on the counter or the buffer.
REQ-013 On each edge with busy=1, the block SHALL write RK[cnt]<=step(RK[cnt-1], Rcon[cnt]) and then cnt<=cnt+1.
REQ-014 step SHALL be the FIPS-197 rule: t=SubWord(RotWord(w3)) xor {Rcon,00,00,00}; w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
REQ-015 The Rcon values for cnt 1..10 SHALL be 01,02,04,08,10,20,40,80,1B,36 (hex).
REQ-016 On the edge that writes RK[NR], the block SHALL set busy<=0, keys_valid<=1 and done<=1; on every other edge done<=0.
REQ-017 Latency SHALL be exactly NR edges from the accept edge to the edge that raises done, i.e. 10 cycles.
REQ-018 A start on the cycle in which done=1 SHALL be accepted, since busy=0 then; keys_valid drops on that accept edge.
REQ-019 Read path: rk_data SHALL take RK[rk_addr] on each edge, giving 1-cycle read latency and updating every cycle independent of busy.
REQ-020 rk_addr>NR SHALL yield rk_data=0.
REQ-021 A read of an entry written on the same edge SHALL return the old value; there is no bypass.
REQ-022 The read path SHALL not gate rk_data with keys_valid; gating is the consumer's responsibility.
REQ-023 cnt SHALL be 4 bits and SHALL never exceed NR; no wrap-around is possible.

Reset
REQ-024 rst=1 SHALL asynchronously force busy=0, done=0, keys_valid=0, cnt=0 and rk_data=0.
REQ-025 Buffer contents SHALL be cleared to 0 on reset.
REQ-026 Reset asserted mid-expansion SHALL abort the expansion; the first start after deassertion SHALL be accepted normally.

Structure
REQ-027 Package aes_pkg SHALL hold the S-box table, the Rcon table, NR_128=10 and the round-key type (128-bit vector).
REQ-028 There SHALL be one combinational sub-module, aes_key_step (inputs: prev_rk, rcon; output: next_rk), containing the 4 S-box lookups.
REQ-029 The top level SHALL contain the control FSM (IDLE/EXPAND, encoded by busy), the counter, the 11x128 buffer and the read register.

Verification
REQ-030 The bench SHALL apply key 2b7e151628aed2a6abf7158809cf4f3c and start -> done after 10 cycles; RK1=a0fafe1788542cb123a339392a6c7605; RK10=d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-031 The bench SHALL apply an all-zero key -> RK1=62636363626363636263636362636363; RK10=b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-032 The bench SHALL pulse start with a new key 4 cycles after an accepted start -> the second start is ignored and RK10 matches the first key.
REQ-033 The bench SHALL assert start on the done cycle with the zero key -> keys_valid=0 next cycle, then done 10 cycles later with the zero-key schedule.
REQ-034 The bench SHALL assert rst at cycle 5 of an expansion -> busy, done, keys_valid and rk_data are 0 immediately; a restart then completes correctly.
REQ-035 The bench SHALL read with rk_addr=11..15 -> rk_data=0; rk_addr=0 returns key_in one cycle later.
